// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache-to-slow-memory line interface.
package mem_if_pkg;

  localparam int unsigned LINE_W      = 128;
  localparam int unsigned ADDR_W      = 28;
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STAT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_line_array.sv
// Line-wide synchronous RAM: unreset storage plus a registered, resettable read port.
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [LINE_W-1:0]     wdata_i,
  output logic [LINE_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_W-1:0] mem [0:DEPTH-1];
  logic [LINE_W-1:0] rdata_q;

  // Storage is intentionally left unreset so it can be preloaded.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line memory responder (IDLE/BUSY/RESP/GAP handshake).
// Optional MEM_RESP_STAT_EN adds saturating read/write completion counters.
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
`ifdef MEM_RESP_STAT_EN
  ,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count
`endif
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic                    mem_ready_q, mem_ready_d;
  logic                    proto_err_q, proto_err_d;

  logic                    req_c;
  logic                    arr_we_c;
  logic                    arr_re_c;
  logic [DEPTH_LOG2-1:0]   arr_idx_c;
  logic [LINE_W-1:0]       arr_wdata_c;

  assign req_c = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      mem_ready_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      mem_ready_q <= mem_ready_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Array access fires on the edge that enters RESP; a zero-wait accept uses live inputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_ready_d = 1'b0;
    proto_err_d = proto_err_q;
    arr_we_c    = 1'b0;
    arr_re_c    = 1'b0;
    arr_idx_c   = idx_q;
    arr_wdata_c = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          op_wr_d = mem_write;
          idx_d   = mem_addr[DEPTH_LOG2-1:0];
          wdata_d = mem_wdata;
          if (mem_read && mem_write) begin
            proto_err_d = 1'b1;
          end
          if (LATENCY == LATENCY_MIN) begin
            state_d     = RESP;
            cnt_d       = '0;
            mem_ready_d = 1'b1;
            arr_we_c    = mem_write;
            arr_re_c    = ~mem_write;
            arr_idx_c   = mem_addr[DEPTH_LOG2-1:0];
            arr_wdata_c = mem_wdata;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (!req_c) begin
          proto_err_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = RESP;
          mem_ready_d = 1'b1;
          arr_we_c    = op_wr_q;
          arr_re_c    = ~op_wr_q;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_line_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we_c & ~rst),
    .re_i    (arr_re_c),
    .idx_i   (arr_idx_c),
    .wdata_i (arr_wdata_c),
    .rdata_o (mem_rdata)
  );

  assign mem_ready = mem_ready_q;
  assign proto_err = proto_err_q;

`ifdef MEM_RESP_STAT_EN
  logic [STAT_W-1:0] rd_count_q, wr_count_q;

  // Counts bump during the single RESP cycle and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == RESP) begin
      if (op_wr_q && (wr_count_q != {STAT_W{1'b1}})) begin
        wr_count_q <= wr_count_q + STAT_W'(1);
      end
      if (!op_wr_q && (rd_count_q != {STAT_W{1'b1}})) begin
        rd_count_q <= rd_count_q + STAT_W'(1);
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed self-checking bench for mem_line_responder (LATENCY=4, 256 lines).
module tb_mem_line_responder;

  localparam int unsigned LAT = 4;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         proto_err;
`ifdef MEM_RESP_STAT_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] P_LINE = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] W_LINE = {4{32'hDEADF625}};
  localparam logic [127:0] G_LINE = 128'h11112222333344445555666677778888;
  localparam logic [127:0] A_LINE = 128'hA5A5A5A5_00000100_5A5A5A5A_C0FFEE00;
  localparam logic [127:0] B_LINE = 128'hBBBBBBBB_00000003_CAFEBABE_12345678;
  localparam logic [127:0] Z_LINE = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_line_responder #(
    .LATENCY    (LAT),
    .DEPTH_LOG2 (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .proto_err (proto_err)
`ifdef MEM_RESP_STAT_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  // Holds a request until mem_ready, then waits 'tail' edges (2 = back in IDLE).
  task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input int tail,
                     output logic [127:0] q, output int lat);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin lat = i; break; end
    end
    q = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    if (lat == 0) begin
      total++;
      $display("FAIL txn_timeout addr=%h: no mem_ready within 40 cycles, required a pulse", a);
    end else begin
      for (int k = 0; k < tail; k++) begin @(posedge clk); #1; end
    end
  endtask

  // Read whose request is dropped while the responder is still BUSY.
  task automatic drop_read(input logic [27:0] a, output logic [127:0] q, output int lat);
    mem_read = 1'b1; mem_addr = a;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) mem_read = 1'b0;
      if (mem_ready) begin lat = i; break; end
    end
    q = mem_rdata;
    mem_addr = '0;
    if (lat == 0) begin
      total++;
      $display("FAIL drop_timeout addr=%h: no mem_ready within 40 cycles, required a pulse", a);
    end else begin
      @(posedge clk); #1; @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    #1;
    total++; if (mem_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", mem_ready); else passed++;
    total++; if (mem_rdata !== 128'h0) $display("FAIL reset_rdata got %h want 0", mem_rdata); else passed++;
    total++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got %b want 0", proto_err); else passed++;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    total++; if (mem_ready !== 1'b0) $display("FAIL idle_ready got %b want 0", mem_ready); else passed++;
  endtask

  task automatic test_read_latency();
    logic [127:0] q;
    int lat;
    txn(1'b0, 1'b1, 28'h5, P_LINE, 2, q, lat);
    total++; if (lat != LAT) $display("FAIL write5_latency got %0d want %0d", lat, LAT); else passed++;
    mem_read = 1'b1; mem_addr = 28'h5;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      total++;
      if (mem_ready !== (c == 4)) $display("FAIL read_ready_cycle%0d got %b want %b", c, mem_ready, (c == 4));
      else passed++;
      if (c == 4) begin
        total++; if (mem_rdata !== P_LINE) $display("FAIL read5_data got %h want %h", mem_rdata, P_LINE); else passed++;
        mem_read = 1'b0; mem_addr = '0;
      end
      if (c == 5) begin
        total++; if (mem_rdata !== P_LINE) $display("FAIL gap_rdata_hold got %h want %h", mem_rdata, P_LINE); else passed++;
      end
    end
  endtask

  task automatic test_write_read();
    logic [127:0] q;
    int lat;
    txn(1'b0, 1'b1, 28'h1A, W_LINE, 2, q, lat);
    total++; if (lat != LAT) $display("FAIL write1a_latency got %0d want %0d", lat, LAT); else passed++;
    txn(1'b1, 1'b0, 28'h1A, '0, 2, q, lat);
    total++; if (lat != LAT) $display("FAIL read1a_back_to_back_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if (q !== W_LINE) $display("FAIL read1a_data got %h want %h", q, W_LINE); else passed++;
  endtask

  task automatic test_gap_ignore();
    logic [127:0] q;
    int lat;
    txn(1'b0, 1'b1, 28'h2B, G_LINE, 1, q, lat);
    total++; if (mem_ready !== 1'b0) $display("FAIL gap_ready got %b want 0", mem_ready); else passed++;
    txn(1'b1, 1'b0, 28'h2B, '0, 2, q, lat);
    total++; if (lat != LAT + 1) $display("FAIL gap_request_latency got %0d want %0d", lat, LAT + 1); else passed++;
    total++; if (q !== G_LINE) $display("FAIL read2b_data got %h want %h", q, G_LINE); else passed++;
  endtask

  task automatic test_alias();
    logic [127:0] q;
    int lat;
    txn(1'b0, 1'b1, 28'h100, A_LINE, 2, q, lat);
    txn(1'b1, 1'b0, 28'h000, '0, 2, q, lat);
    total++; if (q !== A_LINE) $display("FAIL alias_data got %h want %h", q, A_LINE); else passed++;
    total++; if (proto_err !== 1'b0) $display("FAIL alias_proto_err got %b want 0", proto_err); else passed++;
  endtask

  task automatic test_violations();
    logic [127:0] q;
    int lat;
    txn(1'b1, 1'b1, 28'h3, B_LINE, 2, q, lat);
    total++; if (proto_err !== 1'b1) $display("FAIL both_proto_err got %b want 1", proto_err); else passed++;
    txn(1'b1, 1'b0, 28'h3, '0, 2, q, lat);
    total++; if (q !== B_LINE) $display("FAIL both_is_write got %h want %h", q, B_LINE); else passed++;
    drop_read(28'h3, q, lat);
    total++; if (lat != LAT) $display("FAIL drop_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if (proto_err !== 1'b1) $display("FAIL drop_proto_sticky got %b want 1", proto_err); else passed++;
    do_reset();
    total++; if (proto_err !== 1'b0) $display("FAIL rst_clears_proto_err got %b want 0", proto_err); else passed++;
    drop_read(28'h3, q, lat);
    total++; if (q !== B_LINE) $display("FAIL drop_data got %h want %h", q, B_LINE); else passed++;
    total++; if (proto_err !== 1'b1) $display("FAIL drop_sets_proto_err got %b want 1", proto_err); else passed++;
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] q;
    int lat;
    txn(1'b1, 1'b0, 28'h1A, '0, 2, q, lat);
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'h1A; mem_wdata = Z_LINE;
    @(posedge clk); #1; @(posedge clk); #1;
    total++; if (proto_err !== 1'b1) $display("FAIL pre_rst_proto_err got %b want 1", proto_err); else passed++;
    rst = 1'b1;
    #1;
    total++; if (mem_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", mem_ready); else passed++;
    total++; if (mem_rdata !== 128'h0) $display("FAIL midrst_rdata got %h want 0", mem_rdata); else passed++;
    total++; if (proto_err !== 1'b0) $display("FAIL midrst_proto_err got %b want 0", proto_err); else passed++;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 28'h1A, '0, 2, q, lat);
    total++; if (q !== W_LINE) $display("FAIL midrst_old_data got %h want %h", q, W_LINE); else passed++;
    total++; if (lat != LAT) $display("FAIL post_rst_latency got %0d want %0d", lat, LAT); else passed++;
  endtask

`ifdef MEM_RESP_STAT_EN
  task automatic test_stats();
    logic [127:0] q;
    int lat;
    do_reset();
    txn(1'b1, 1'b0, 28'h1A, '0, 2, q, lat);
    txn(1'b0, 1'b1, 28'h40, G_LINE, 2, q, lat);
    txn(1'b1, 1'b0, 28'h3, '0, 2, q, lat);
    txn(1'b0, 1'b1, 28'h41, A_LINE, 2, q, lat);
    txn(1'b1, 1'b0, 28'h5, '0, 2, q, lat);
    total++; if (rd_count !== 16'd3) $display("FAIL stat_rd_count got %0d want 3", rd_count); else passed++;
    total++; if (wr_count !== 16'd2) $display("FAIL stat_wr_count got %0d want 2", wr_count); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_gap_ignore();
    test_alias();
    test_violations();
    test_reset_mid_write();
`ifdef MEM_RESP_STAT_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
